// File: rtl/sccb_config_sequencer.sv
// Camera register init sequencer: walks a {reg_addr, reg_data} LUT and issues one SCCB write
// per entry over a req/ack handshake, with power-up / soft-reset delays and per-entry retries.
//
// state     | meaning
// PWR_WAIT  | power-up delay before the first write
// FETCH     | LUT read latency
// ISSUE     | latch LUT entry and raise request, or finish on the end marker
// WAIT_ACK  | request held until ack or timeout
// POST_WAIT | settle time after sensor soft reset (0x12 <= 0x80)
// NEXT      | advance LUT index or finish
// DONE      | all entries written, Config_Done held
// FAIL      | an entry exhausted its retries, Config_Err held
module sccb_config_sequencer #(
  parameter int unsigned LUT_SIZE       = 168,
  parameter int unsigned IDX_W          = 8,
  parameter int unsigned POWERUP_CYCLES = 1000000,
  parameter int unsigned RESET_WAIT     = 100000,
  parameter int unsigned ACK_TIMEOUT    = 50000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iRESTART,
  output logic [IDX_W-1:0] LUT_INDEX,
  input  logic [15:0]      LUT_DATA,
  output logic             SCCB_REQ,
  output logic [7:0]       SCCB_ADDR,
  output logic [7:0]       SCCB_WDATA,
  input  logic             SCCB_ACK,
  input  logic             SCCB_NACK,
  output logic             Config_Done,
  output logic             Config_Err,
  output logic [IDX_W-1:0] ERR_INDEX
);

  localparam int unsigned MAX_AB  = (POWERUP_CYCLES > RESET_WAIT) ? POWERUP_CYCLES : RESET_WAIT;
  localparam int unsigned MAX_DLY = (MAX_AB > ACK_TIMEOUT) ? MAX_AB : ACK_TIMEOUT;
  localparam int CNT_W = (MAX_DLY > 2) ? $clog2(MAX_DLY) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] PWR_TC   = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_TC   = CNT_W'(RESET_WAIT - 1);
  localparam logic [CNT_W-1:0] ACK_TC   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);

  typedef enum logic [2:0] {
    PWR_WAIT, FETCH, ISSUE, WAIT_ACK, POST_WAIT, NEXT, DONE, FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= PWR_WAIT;
      cnt_q     <= '0;
      retry_q   <= '0;
      idx_q     <= '0;
      err_idx_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      req_q     <= req_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_d     = req_q;
    done_d    = done_q;
    err_d     = err_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_TC) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        cnt_d = '0;
        if (LUT_DATA == 16'hFFFF) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = LUT_DATA[15:8];
          wdata_d = LUT_DATA[7:0];
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // a real ack wins over a timeout expiring in the same cycle
        if (SCCB_ACK && !SCCB_NACK) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = (addr_q == 8'h12 && wdata_q == 8'h80) ? POST_WAIT : NEXT;
        end else if (SCCB_ACK || cnt_q == ACK_TC) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ISSUE;
          end else begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = FAIL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      POST_WAIT: begin
        if (cnt_q == RST_TC) begin
          cnt_d   = '0;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NEXT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH;
        end
      end
      DONE, FAIL: begin
        req_d = 1'b0;
        if (iRESTART) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          retry_d   = '0;
          cnt_d     = '0;
          state_d   = PWR_WAIT;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  assign LUT_INDEX   = idx_q;
  assign SCCB_REQ    = req_q;
  assign SCCB_ADDR   = addr_q;
  assign SCCB_WDATA  = wdata_q;
  assign Config_Done = done_q;
  assign Config_Err  = err_q;
  assign ERR_INDEX   = err_idx_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: a responsive SCCB master plus a transaction-level model that
// predicts every request (start cycle, addr, data, length) and the final Done/Err outcome.
module tb_sccb_config_sequencer;

  localparam int PWR = 16;
  localparam int N   = 4;
  localparam int RW  = 8;
  localparam int TMO = 32;
  localparam int MR  = 3;
  localparam int K_ACK = 0, K_NACK = 1, K_TMO = 2;

  logic        iCLK = 1'b0;
  logic        iRST_N, iRESTART;
  logic [7:0]  LUT_INDEX;
  logic [15:0] LUT_DATA;
  logic        SCCB_REQ, SCCB_ACK, SCCB_NACK;
  logic [7:0]  SCCB_ADDR, SCCB_WDATA;
  logic        Config_Done, Config_Err;
  logic [7:0]  ERR_INDEX;

  sccb_config_sequencer #(
    .LUT_SIZE(N), .IDX_W(8), .POWERUP_CYCLES(PWR), .RESET_WAIT(RW),
    .ACK_TIMEOUT(TMO), .MAX_RETRY(MR)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRESTART(iRESTART),
    .LUT_INDEX(LUT_INDEX), .LUT_DATA(LUT_DATA),
    .SCCB_REQ(SCCB_REQ), .SCCB_ADDR(SCCB_ADDR), .SCCB_WDATA(SCCB_WDATA),
    .SCCB_ACK(SCCB_ACK), .SCCB_NACK(SCCB_NACK),
    .Config_Done(Config_Done), .Config_Err(Config_Err), .ERR_INDEX(ERR_INDEX)
  );

  always #5 iCLK = ~iCLK;

  logic [15:0] lut [N];
  always @(posedge iCLK) LUT_DATA <= lut[LUT_INDEX[1:0]];

  int plan_kind [16];
  int plan_lat  [16];

  int total = 0, bad = 0;
  int cyc, hcnt, mptr, cur_kind, cur_lat;
  bit req_prev, noise_en, poke_en, poked, unstable;

  int         exp_start[$], exp_len[$];
  logic [7:0] exp_addr[$], exp_data[$];
  int         obs_start[$], obs_len[$];
  logic [7:0] obs_addr[$], obs_data[$];
  int         exp_end, exp_idx, exp_eidx;
  bit         exp_done, exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Transaction-level prediction: each attempt lasts its ack latency (or the full timeout),
  // a retry costs a 1-cycle gap, a success costs FETCH/ISSUE/NEXT plus the soft-reset settle.
  task automatic build_model(input int base);
    int t, p, len;
    bit ok;
    exp_start.delete(); exp_len.delete(); exp_addr.delete(); exp_data.delete();
    t = base + PWR + 2;
    p = 0;
    exp_done = 0; exp_err = 0; exp_eidx = 0; exp_end = 0; exp_idx = N - 1;
    for (int i = 0; i < N; i++) begin
      if (lut[i] == 16'hFFFF) begin
        exp_done = 1; exp_end = t; exp_idx = i;
        return;
      end
      ok = 0;
      for (int a = 0; a <= MR && !ok; a++) begin
        len = (plan_kind[p] == K_TMO) ? TMO : plan_lat[p];
        exp_start.push_back(t); exp_len.push_back(len);
        exp_addr.push_back(lut[i][15:8]); exp_data.push_back(lut[i][7:0]);
        if (plan_kind[p] == K_ACK) begin
          ok = 1;
          t = t + len + 3 + ((lut[i] == 16'h1280) ? RW : 0);
        end else begin
          t = t + len + 1;
        end
        p++;
      end
      if (!ok) begin
        exp_err = 1; exp_eidx = i; exp_idx = i; exp_end = t - 1;
        return;
      end
    end
    exp_done = 1; exp_end = t - 2;
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
    cyc++;
    SCCB_ACK = 1'b0; SCCB_NACK = 1'b0;
    if (poke_en) iRESTART = 1'b0;
    if (SCCB_REQ) begin
      if (!req_prev) begin
        obs_start.push_back(cyc); obs_addr.push_back(SCCB_ADDR); obs_data.push_back(SCCB_WDATA);
        hcnt = 0;
        cur_kind = (mptr < 16) ? plan_kind[mptr] : K_TMO;
        cur_lat  = (mptr < 16) ? plan_lat[mptr] : TMO;
        mptr++;
      end else if (SCCB_ADDR != obs_addr[$] || SCCB_WDATA != obs_data[$]) begin
        unstable = 1;
      end
      hcnt++;
      if (cur_kind != K_TMO && hcnt == cur_lat) begin
        SCCB_ACK = 1'b1; SCCB_NACK = (cur_kind == K_NACK);
      end
      if (poke_en && !poked) begin
        iRESTART = 1'b1; poked = 1;
      end
    end else begin
      if (req_prev) obs_len.push_back(hcnt);
      if (noise_en && $urandom_range(0, 3) == 0) begin
        SCCB_ACK = 1'b1; SCCB_NACK = 1'($urandom_range(0, 1));
      end
    end
    req_prev = SCCB_REQ;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0; iRESTART = 1'b0; SCCB_ACK = 1'b0; SCCB_NACK = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_req_addr_data", {15'd0, SCCB_REQ, SCCB_ADDR, SCCB_WDATA}, 32'd0);
    check("rst_done_err_idx", {14'd0, Config_Done, Config_Err, ERR_INDEX, LUT_INDEX}, 32'd0);
    iRST_N = 1'b1;
    cyc = 0; req_prev = 0;
  endtask

  task automatic run_seq(input int base, input string name);
    int g, ov;
    build_model(base);
    obs_start.delete(); obs_len.delete(); obs_addr.delete(); obs_data.delete();
    mptr = 0; poked = 0; unstable = 0; g = 0;
    while (!(Config_Done || Config_Err) && g < 3000) begin
      step();
      g++;
    end
    check({name, "_finished"}, 32'(Config_Done | Config_Err), 32'd1);
    check({name, "_end_cycle"}, cyc, exp_end);
    check({name, "_done"}, 32'(Config_Done), 32'(exp_done));
    check({name, "_err"}, 32'(Config_Err), 32'(exp_err));
    check({name, "_err_index"}, 32'(ERR_INDEX), exp_eidx);
    check({name, "_lut_index"}, 32'(LUT_INDEX), exp_idx);
    check({name, "_req_low"}, 32'(SCCB_REQ), 32'd0);
    check({name, "_req_count"}, obs_start.size(), exp_start.size());
    check({name, "_stable"}, 32'(unstable), 32'd0);
    for (int i = 0; i < exp_start.size(); i++) begin
      ov = (i < obs_start.size()) ? obs_start[i] : -1;
      check($sformatf("%s_start%0d", name, i), ov, exp_start[i]);
      ov = (i < obs_len.size()) ? obs_len[i] : -1;
      check($sformatf("%s_len%0d", name, i), ov, exp_len[i]);
      ov = (i < obs_addr.size()) ? 32'(obs_addr[i]) : -1;
      check($sformatf("%s_addr%0d", name, i), ov, 32'(exp_addr[i]));
      ov = (i < obs_data.size()) ? 32'(obs_data[i]) : -1;
      check($sformatf("%s_data%0d", name, i), ov, 32'(exp_data[i]));
    end
  endtask

  task automatic plan_all(input int kind, input int lat);
    for (int k = 0; k < 16; k++) begin
      plan_kind[k] = kind; plan_lat[k] = lat;
    end
  endtask

  initial begin
    int r, g;
    noise_en = 0; poke_en = 0;
    lut[0] = 16'h1280; lut[1] = 16'h1100; lut[2] = 16'h0C04; lut[3] = 16'h3E19;

    // clean run, then restart from DONE and replay with a restart poke inside WAIT_ACK
    plan_all(K_ACK, 5);
    do_reset();
    run_seq(0, "basic");
    check("basic_first_req_cycle", obs_start.size() > 0 ? obs_start[0] : -1, 18);
    iRESTART = 1'b1;
    step();
    iRESTART = 1'b0;
    check("restart_done_fall", 32'(Config_Done), 32'd0);
    check("restart_lut_index", 32'(LUT_INDEX), 32'd0);
    poke_en = 1;
    run_seq(cyc, "replay");
    poke_en = 0;

    // entry 1 NACKed twice, then acked
    plan_all(K_ACK, 5);
    plan_kind[1] = K_NACK; plan_kind[2] = K_NACK;
    do_reset();
    run_seq(0, "nack");

    // entry 2 never acked
    plan_all(K_TMO, TMO);
    plan_kind[0] = K_ACK; plan_lat[0] = 5;
    plan_kind[1] = K_ACK; plan_lat[1] = 5;
    do_reset();
    run_seq(0, "timeout");

    // ack landing in the same cycle as timeout expiry counts as success
    plan_all(K_ACK, TMO);
    do_reset();
    run_seq(0, "ack_at_tmo");

    // restart out of FAIL
    plan_all(K_NACK, 2);
    do_reset();
    run_seq(0, "fail0");
    iRESTART = 1'b1;
    step();
    iRESTART = 1'b0;
    check("restart_err_fall", 32'({Config_Err, ERR_INDEX}), 32'd0);
    plan_all(K_ACK, 3);
    run_seq(cyc, "after_fail");

    // early end marker at entry 1
    lut[1] = 16'hFFFF;
    plan_all(K_ACK, 5);
    do_reset();
    run_seq(0, "marker");
    lut[1] = 16'h1100;

    // async reset while a request is outstanding
    plan_all(K_ACK, 8);
    do_reset();
    g = 0;
    while (!(SCCB_REQ && LUT_INDEX == 8'd2) && g < 300) begin
      step();
      g++;
    end
    check("async_reached_req", 32'({SCCB_REQ, LUT_INDEX}), 32'h102);
    #3;
    iRST_N = 1'b0;
    #1;
    check("async_req_drop", 32'(SCCB_REQ), 32'd0);
    check("async_index_clear", 32'(LUT_INDEX), 32'd0);
    do_reset();
    run_seq(0, "post_async");

    // randomized LUTs and master responses, with spurious acks and stray restarts
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) begin
        r = int'($urandom_range(0, 99));
        lut[i] = (r < 20) ? 16'h1280 : (r < 27) ? 16'hFFFF : 16'($urandom_range(0, 65534));
      end
      for (int k = 0; k < 16; k++) begin
        r = int'($urandom_range(0, 99));
        plan_kind[k] = (r < 60) ? K_ACK : (r < 85) ? K_NACK : K_TMO;
        plan_lat[k]  = ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(1, 8));
      end
      noise_en = 1;
      poke_en  = (s % 2 == 1);
      do_reset();
      run_seq(0, $sformatf("rand%0d", s));
    end
    noise_en = 0; poke_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sccb_config_sequencer.md
Name: sccb_config_sequencer

Overview:
Controller that sequences camera register initialisation over a byte-level SCCB/I2C write master. Walks an external register LUT of {reg_addr, reg_data} pairs and issues one write transaction per entry over a req/ack handshake. Applies a power-up delay and a post-soft-reset delay, and retries NACKed or timed-out writes. Produces the Config_Done flag that gates CMOS capture, and sits between the camera clock domain (xclk) and the SCCB master.

Parameters:
LUT_SIZE, 168, number of LUT entries (index range 0..LUT_SIZE-1)
IDX_W, 8, width of LUT index
POWERUP_CYCLES, 20'd1000000, iCLK cycles waited after reset/restart before the first write
RESET_WAIT, 20'd100000, cycles waited after a write of 0x80 to register 0x12 (sensor soft reset)
ACK_TIMEOUT, 16'd50000, cycles allowed between req rise and ack before the write counts as a failure
MAX_RETRY, 3, retries per entry before FAIL

Ports:
iCLK input 1 sequencer clock
iRST_N input 1 asynchronous active-low reset
iRESTART input 1 one-cycle pulse; re-runs the full sequence from DONE or FAIL only
LUT_INDEX output IDX_W current LUT address
LUT_DATA input 16 LUT contents {reg_addr[15:8], reg_data[7:0]}, valid 1 cycle after LUT_INDEX changes
SCCB_REQ output 1 write request to SCCB master
SCCB_ADDR output 8 register address for the request
SCCB_WDATA output 8 register data for the request
SCCB_ACK input 1 one-cycle completion pulse from the master
SCCB_NACK input 1 qualifies SCCB_ACK; 1 = slave NACK
Config_Done output 1 high when all entries have been written successfully
Config_Err output 1 high in FAIL
ERR_INDEX output IDX_W LUT index of the failing entry

Behaviour:
- Reset values: LUT_INDEX=0, SCCB_REQ=0, SCCB_ADDR=0, SCCB_WDATA=0, Config_Done=0, Config_Err=0, ERR_INDEX=0, state=PWR_WAIT, delay counter=0, retry counter=0. Reset asserted mid-transaction drops SCCB_REQ immediately (async).
- States: PWR_WAIT, FETCH, ISSUE, WAIT_ACK, POST_WAIT, NEXT, DONE, FAIL.
- PWR_WAIT: count to POWERUP_CYCLES-1, then go to FETCH.
- FETCH: one cycle for LUT read latency, then ISSUE.
- ISSUE: latch LUT_DATA into SCCB_ADDR/SCCB_WDATA and assert SCCB_REQ. Go to WAIT_ACK.
- Early end marker: LUT_DATA==16'hFFFF is not written; go directly to DONE.
- WAIT_ACK: SCCB_REQ is held high and ADDR/WDATA are stable until SCCB_ACK is seen.
  - SCCB_REQ drops in the cycle after SCCB_ACK is sampled, so the master sees exactly one request per ack.
  - Ack with NACK=0: success. Go to POST_WAIT if ADDR==8'h12 and WDATA==8'h80, else NEXT.
  - Ack with NACK=1, or timeout counter reaching ACK_TIMEOUT-1 without ack: failure.
  - On failure, if retry<MAX_RETRY: retry+1, drop REQ for one cycle, then return to ISSUE with the same entry. Otherwise latch ERR_INDEX=LUT_INDEX and go to FAIL.
  - Timeout counter clears on every ISSUE.
- POST_WAIT: count to RESET_WAIT-1, then NEXT.
- NEXT: clear retry. If LUT_INDEX==LUT_SIZE-1, go to DONE. Else LUT_INDEX+1, then FETCH.
- DONE: Config_Done=1 (registered, held), SCCB_REQ=0.
- FAIL: Config_Err=1, SCCB_REQ=0.
- iRESTART in DONE/FAIL: clear Done/Err/ERR_INDEX, LUT_INDEX=0, retry=0, go to PWR_WAIT. iRESTART in any other state is ignored.
- SCCB_ACK arriving outside WAIT_ACK is ignored.
- An ack in the same cycle as the timeout expiry takes priority as a real ack.
- Counters are wide enough for the largest delay parameter. No wrap-around: each counter stops at its terminal value and is cleared on state entry.
- Throughput: the minimum per-entry overhead outside the master is 3 cycles (FETCH, ISSUE, NEXT).

Test Plan:
- Params POWERUP_CYCLES=16, LUT_SIZE=4, LUT={0x1280,0x1100,0x0C04,0x3E19}, RESET_WAIT=8, master acks 5 cycles after req with NACK=0 -> first SCCB_REQ rises 18 cycles after reset release (16 PWR_WAIT + FETCH + ISSUE); entry 0 (0x1280) is followed by 8 POST_WAIT cycles; exactly 4 req/ack pairs with ADDR/WDATA 12/80, 11/00, 0C/04, 3E/19; Config_Done=1 after the 4th ack; Config_Err=0.
- Entry 1 NACKed twice, then acked (MAX_RETRY=3) -> 3 requests with ADDR=0x11 and WDATA=0x00, each separated by a 1-cycle REQ low gap; sequence completes and Config_Done=1.
- Entry 2 never acked, ACK_TIMEOUT=32, MAX_RETRY=3 -> 4 requests each lasting 32 cycles, then Config_Err=1, ERR_INDEX=2, SCCB_REQ=0, Config_Done=0.
- LUT entry 1 = 0xFFFF -> only entry 0 is written; Config_Done=1 with no request for index 1.
- iRSTART pulse in DONE -> Config_Done falls next cycle, LUT_INDEX=0, 16-cycle power wait, full sequence replays; the same pulse during WAIT_ACK has no effect.
- iRST_N asserted while SCCB_REQ=1 in WAIT_ACK -> SCCB_REQ=0 asynchronously; after release the sequencer restarts at PWR_WAIT with LUT_INDEX=0.
